sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// =============================================================================
// sram_arbiter : two-port round-robin arbiter sequencing one external async SRAM
// Revision     : 1.0
// =============================================================================
module sram_arbiter #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0]           req_we,
   input  logic [ADDR_BITS-1:0] req_addr0,
   input  logic [ADDR_BITS-1:0] req_addr1,
   input  logic [DATA_BITS-1:0] req_wdata0,
   input  logic [DATA_BITS-1:0] req_wdata1,
   output logic [1:0]           resp_valid,
   output logic [DATA_BITS-1:0] resp_rdata,
   output logic [ADDR_BITS-1:0] addr_bus,
   inout  wire  [DATA_BITS-1:0] data_bus,
   output logic                 we_n,
   output logic                 oe_n,
   output logic                 ce_n
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD1  = 3'd1;
   localparam logic [2:0] S_RD2  = 3'd2;
   localparam logic [2:0] S_WR1  = 3'd3;
   localparam logic [2:0] S_WR2  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic                 port_q, port_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;
   logic                 drive_q, drive_d;
   logic                 we_n_q, we_n_d;
   logic                 oe_n_q, oe_n_d;
   logic                 ce_n_q, ce_n_d;
   logic [1:0]           resp_valid_q, resp_valid_d;
   logic [DATA_BITS-1:0] resp_rdata_q, resp_rdata_d;

   logic                 grant;
   logic                 accept;

   // Round-robin: on contention the port that did not win last time is granted.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b10) begin
         grant = 1'b1;
      end else if (req_valid == 2'b11) begin
         grant = ~last_grant_q;
      end
      req_ready = 2'b00;
      if (reset_n && state_q == S_IDLE && req_valid != 2'b00) begin
         req_ready = grant ? 2'b10 : 2'b01;
      end
      accept = |(req_valid & req_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         drive_q      <= 1'b0;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         ce_n_q       <= 1'b1;
         resp_valid_q <= 2'b00;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         drive_q      <= drive_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
         ce_n_q       <= ce_n_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d      = req_we[grant] ? S_WR1 : S_RD1;
               last_grant_d = grant;
               port_d       = grant;
            end
         end
         S_RD1:   state_d = S_RD2;
         S_RD2:   state_d = S_IDLE;
         S_WR1:   state_d = S_WR2;
         S_WR2:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are computed for the state being entered so they are registered.
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ce_n_d       = 1'b1;
      oe_n_d       = 1'b1;
      we_n_d       = 1'b1;
      drive_d      = 1'b0;
      resp_valid_d = 2'b00;
      resp_rdata_d = resp_rdata_q;
      if (state_q == S_IDLE && accept) begin
         addr_d  = grant ? req_addr1  : req_addr0;
         wdata_d = grant ? req_wdata1 : req_wdata0;
      end
      if (state_q == S_RD2) begin
         resp_rdata_d         = data_bus;
         resp_valid_d[port_q] = 1'b1;
      end
      case (state_d)
         S_RD1, S_RD2: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         S_WR1: begin
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         S_WR2: begin
            ce_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         default: begin
            ce_n_d = 1'b1;
         end
      endcase
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign addr_bus   = addr_q;
   assign we_n       = we_n_q;
   assign oe_n       = oe_n_q;
   assign ce_n       = ce_n_q;
   assign data_bus   = drive_q ? wdata_q : {DATA_BITS{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// =============================================================================
// tb_sram_arbiter : self-checking bench for sram_arbiter with an async SRAM model
// Revision        : 1.0
// =============================================================================
module tb_sram_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [1:0]    req_we = 2'b00;
   logic [AW-1:0] req_addr0 = '0;
   logic [AW-1:0] req_addr1 = '0;
   logic [DW-1:0] req_wdata0 = '0;
   logic [DW-1:0] req_wdata1 = '0;
   wire  [1:0]    req_ready;
   wire  [1:0]    resp_valid;
   wire  [DW-1:0] resp_rdata;
   wire  [AW-1:0] addr_bus;
   wire  [DW-1:0] data_bus;
   wire           we_n, oe_n, ce_n;

   sram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .addr_bus(addr_bus), .data_bus(data_bus),
      .we_n(we_n), .oe_n(oe_n), .ce_n(ce_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM model: writes land while we_n is low, reads drive when oe_n is low.
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [DW-1:0] sram_rd = '0;
   wire           sram_oe = !ce_n && !oe_n && we_n;
   assign data_bus = sram_oe ? sram_rd : {DW{1'bz}};

   always @(negedge clk) begin
      if (!ce_n && !we_n) mem[addr_bus] = data_bus;
      if (!ce_n && !oe_n) sram_rd = mem.exists(addr_bus) ? mem[addr_bus] : 16'hDEAD;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pin/handshake protocol watched every cycle while out of reset.
   always begin
      @(negedge clk);
      #3;
      if (reset_n) begin
         check("proto_oe_we_low", {31'b0, (!oe_n && !we_n)}, 32'd0);
         check("proto_ready_both", {31'b0, (req_ready == 2'b11)}, 32'd0);
         check("proto_ready_busy", {31'b0, (!ce_n && req_ready != 2'b00)}, 32'd0);
      end
   end

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [1:0]    valid;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    exp_ready;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vt[10];

   task automatic run_vec(input vec_t v, input int idx);
      logic          g;
      logic          is_wr;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      req_valid  = v.valid;
      req_we     = v.we;
      req_addr0  = v.a0;
      req_addr1  = v.a1;
      req_wdata0 = v.d0;
      req_wdata1 = v.d1;
      #1;
      check($sformatf("vec%0d_ready", idx), req_ready, v.exp_ready);
      check($sformatf("vec%0d_idle_pins", idx), {ce_n, oe_n, we_n}, 3'b111);
      g     = v.exp_ready[1];
      is_wr = v.we[g];
      ea    = g ? v.a1 : v.a0;
      ed    = g ? v.d1 : v.d0;
      @(posedge clk); #1;
      req_valid = 2'b00;
      check($sformatf("vec%0d_addr", idx), addr_bus, ea);
      if (is_wr) begin
         check($sformatf("vec%0d_wr1_pins", idx), {ce_n, oe_n, we_n}, 3'b010);
         check($sformatf("vec%0d_wr1_data", idx), data_bus, ed);
      end else begin
         check($sformatf("vec%0d_rd1_pins", idx), {ce_n, oe_n, we_n}, 3'b001);
      end
      @(posedge clk); #1;
      if (is_wr) begin
         check($sformatf("vec%0d_wr2_pins", idx), {ce_n, oe_n, we_n}, 3'b011);
         check($sformatf("vec%0d_wr2_data", idx), data_bus, ed);
      end else begin
         check($sformatf("vec%0d_rd2_pins", idx), {ce_n, oe_n, we_n}, 3'b001);
      end
      check($sformatf("vec%0d_no_early_resp", idx), resp_valid, 2'b00);
      @(posedge clk); #1;
      check($sformatf("vec%0d_back_idle", idx), {ce_n, oe_n, we_n}, 3'b111);
      check($sformatf("vec%0d_addr_hold", idx), addr_bus, ea);
      check($sformatf("vec%0d_resp_valid", idx), resp_valid, is_wr ? 2'b00 : v.exp_ready);
      if (!is_wr) check($sformatf("vec%0d_rdata", idx), resp_rdata, v.exp_rdata);
      @(posedge clk); #1;
      check($sformatf("vec%0d_resp_pulse", idx), resp_valid, 2'b00);
   endtask

   // Reference model state for the randomized phase.
   typedef struct {
      logic [AW-1:0] a;
      logic          we;
      logic [DW-1:0] d;
   } req_t;

   req_t          cur[2];
   logic [1:0]    pend;
   logic [DW-1:0] mmem [16];
   int            free_cyc;
   logic          m_last;
   int            due_cyc;
   logic          due_port;
   logic [DW-1:0] due_data;

   initial begin
      logic [1:0]    exp_rv;
      logic [1:0]    exp_rdy;
      logic          g;

      // Contended reads straight out of reset.
      mem[20'h00001] = 16'h1111;
      mem[20'h00002] = 16'h2222;
      reset_n   = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr0 = 20'h00001;
      req_addr1 = 20'h00002;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", req_ready, 2'b00);
      check("rst_resp_valid", resp_valid, 2'b00);
      check("rst_rdata", resp_rdata, 16'h0);
      check("rst_addr", addr_bus, 20'h0);
      check("rst_pins", {ce_n, oe_n, we_n}, 3'b111);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         #1;
         exp_rdy = (k % 3 == 0) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         exp_rv  = (k >= 3 && k % 3 == 0) ? ((((k / 3) - 1) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         check($sformatf("rr_ready_k%0d", k), req_ready, exp_rdy);
         check($sformatf("rr_resp_k%0d", k), resp_valid, exp_rv);
         if (exp_rv != 2'b00)
            check($sformatf("rr_rdata_k%0d", k), resp_rdata, exp_rv[1] ? 16'h2222 : 16'h1111);
         @(negedge clk);
      end
      req_valid = 2'b00;
      repeat (4) @(negedge clk);

      // Table of single operations; last_grant evolves across entries.
      do_reset();
      vt[0] = '{2'b01, 2'b01, 20'h00010, 20'h0,     16'hA5A5, 16'h0,    2'b01, 16'h0};
      vt[1] = '{2'b01, 2'b00, 20'h00010, 20'h0,     16'h0,    16'h0,    2'b01, 16'hA5A5};
      vt[2] = '{2'b10, 2'b10, 20'h0,     20'hFFFFF, 16'h0,    16'h1234, 2'b10, 16'h0};
      vt[3] = '{2'b10, 2'b10, 20'h0,     20'h00000, 16'h0,    16'h5678, 2'b10, 16'h0};
      vt[4] = '{2'b11, 2'b00, 20'hFFFFF, 20'h00000, 16'h0,    16'h0,    2'b01, 16'h1234};
      vt[5] = '{2'b11, 2'b00, 20'h00000, 20'hFFFFF, 16'h0,    16'h0,    2'b10, 16'h1234};
      vt[6] = '{2'b11, 2'b00, 20'h00000, 20'hFFFFF, 16'h0,    16'h0,    2'b01, 16'h5678};
      vt[7] = '{2'b10, 2'b00, 20'h0,     20'h00010, 16'h0,    16'h0,    2'b10, 16'hA5A5};
      vt[8] = '{2'b11, 2'b11, 20'h00005, 20'h00006, 16'h0BEE, 16'h0CAF, 2'b01, 16'h0};
      vt[9] = '{2'b11, 2'b00, 20'h00006, 20'h00005, 16'h0,    16'h0,    2'b10, 16'h0BEE};
      for (int i = 0; i < 10; i++) run_vec(vt[i], i);

      // Reset asserted in the middle of a write.
      @(negedge clk);
      req_valid  = 2'b01;
      req_we     = 2'b01;
      req_addr0  = 20'h00020;
      req_wdata0 = 16'hBEEF;
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("mid_wr1_we", {31'b0, we_n}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_pins", {ce_n, oe_n, we_n}, 3'b111);
      check("mid_rst_addr", addr_bus, 20'h0);
      check("mid_rst_resp", resp_valid, 2'b00);
      @(negedge clk);
      reset_n   = 1'b1;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr0 = 20'h00001;
      req_addr1 = 20'h00002;
      #1;
      check("post_rst_grant", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("post_rst_no_resp", resp_valid, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_resp", resp_valid, 2'b01);
      check("post_rst_rdata", resp_rdata, 16'h1111);

      // Randomized traffic against the transaction-level model.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         mmem[i] = 16'($urandom);
         mem[20'(i)] = mmem[i];
      end
      pend     = 2'b00;
      free_cyc = 0;
      m_last   = 1'b1;
      due_cyc  = -1;
      due_port = 1'b0;
      due_data = '0;
      for (int p = 0; p < 2; p++) cur[p] = '{20'h0, 1'b0, 16'h0};
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         exp_rv = 2'b00;
         if (due_cyc == n) exp_rv[due_port] = 1'b1;
         check("rnd_resp_valid", resp_valid, exp_rv);
         if (exp_rv != 2'b00) check("rnd_rdata", resp_rdata, due_data);
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p]   = 1'b1;
               cur[p].a  = 20'($urandom_range(0, 15));
               cur[p].we = 1'($urandom_range(0, 1));
               cur[p].d  = 16'($urandom);
            end
         end
         req_valid  = pend;
         req_we     = {cur[1].we, cur[0].we};
         req_addr0  = cur[0].a;
         req_addr1  = cur[1].a;
         req_wdata0 = cur[0].d;
         req_wdata1 = cur[1].d;
         #1;
         exp_rdy = 2'b00;
         g = 1'b0;
         if (n >= free_cyc && pend != 2'b00) begin
            g = (pend == 2'b11) ? !m_last : pend[1];
            exp_rdy[g] = 1'b1;
         end
         check("rnd_ready", req_ready, exp_rdy);
         if (exp_rdy != 2'b00) begin
            m_last   = g;
            free_cyc = n + 3;
            pend[g]  = 1'b0;
            if (cur[g].we) begin
               mmem[cur[g].a[3:0]] = cur[g].d;
            end else begin
               due_cyc  = n + 3;
               due_port = g;
               due_data = mmem[cur[g].a[3:0]];
            end
         end
      end
      req_valid = 2'b00;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
